// File: rtl/ser_tx_framer.sv
// ser_tx_framer
// ---------------------------------------------------------------------------
// Transmit-side framer for the 16-bit SERDES link. Packets arriving on a
// valid/ready stream are wrapped as:
//     SOP marker (FBFB/K11), payload words (K00), checksum (K00), EOP (FDFD/K11)
// Idle time is filled with 3C3C/K11 commas. Inside a packet a comma is forced
// whenever COMMA_PERIOD-1 non-comma words have been sent in a row, so the
// receiver keeps clock correction.
//
// Handshake: a word on tx_data_i/tx_sop_i/tx_eop_i is transferred on every
// rising edge where tx_valid_i & tx_ready_o. The source holds the word stable
// until that edge. tx_ready_o is combinational from registered state and from
// tx_valid_i/tx_sop_i only; it never depends on tx_data_i or tx_eop_i.
//
// Ports
//   ser_tx_clk_i   link transmit clock, rising edge
//   ser_tx_rst_n   asynchronous active-low reset
//   tx_data_i      payload word
//   tx_sop_i       first word of a packet
//   tx_eop_i       last word of a packet (may coincide with tx_sop_i)
//   tx_valid_i     input word valid
//   tx_ready_o     input word accepted this edge when valid is also high
//   ser_t_o        registered word to the transceiver
//   ser_tklsb_o    ser_t_o[7:0] is a K-character
//   ser_tkmsb_o    ser_t_o[15:8] is a K-character
//   tx_busy_o      framer is inside a packet (state is not IDLE)
//   tx_err_o       one-cycle pulse, one cycle after a protocol-error accept
//   dbg_state_o    current FSM state (0 IDLE, 1 DATA, 2 CSUM, 3 EOP)
// ---------------------------------------------------------------------------
module ser_tx_framer #(
    parameter int unsigned COMMA_PERIOD = 256,  // 4..65535
    parameter int unsigned MIN_IDLE     = 2     // 1..255
) (
    input  logic        ser_tx_clk_i,
    input  logic        ser_tx_rst_n,
    input  logic [15:0] tx_data_i,
    input  logic        tx_sop_i,
    input  logic        tx_eop_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [15:0] ser_t_o,
    output logic        ser_tklsb_o,
    output logic        ser_tkmsb_o,
    output logic        tx_busy_o,
    output logic        tx_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [15:0] K_COMMA     = 16'h3C3C;
    localparam logic [15:0] K_SOP       = 16'hFBFB;
    localparam logic [15:0] K_EOP       = 16'hFDFD;
    localparam logic [15:0] COMMA_LIMIT = 16'(COMMA_PERIOD - 1);
    localparam logic [7:0]  IDLE_MIN    = 8'(MIN_IDLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2,
        ST_EOP  = 2'd3
    } state_e;

    state_e      state_q;
    logic [15:0] comma_cnt_q;   // non-comma words sent since the last comma
    logic [7:0]  idle_cnt_q;    // commas sent since EOP, saturating at MIN_IDLE
    logic [15:0] csum_q;
    logic        first_q;       // next accept in DATA is the packet's SOP word

    logic        comma_due;
    logic        accept;
    logic        start_pkt;
    logic [15:0] comma_cnt_inc;

    // A comma is only forced while payload is flowing; in CSUM/EOP the
    // counter keeps saturating and the comma lands in IDLE instead.
    assign comma_due = (state_q == ST_DATA) && (comma_cnt_q >= COMMA_LIMIT);

    always_comb begin
        tx_ready_o = 1'b0;
        unique case (state_q)
            // Only non-SOP words are taken in IDLE, and they are dropped.
            // The SOP word waits and is consumed as the first DATA word.
            ST_IDLE: tx_ready_o = tx_valid_i & ~tx_sop_i;
            ST_DATA: tx_ready_o = ~comma_due;
            ST_CSUM: tx_ready_o = 1'b0;
            ST_EOP:  tx_ready_o = 1'b0;
        endcase
    end

    assign accept    = tx_valid_i & tx_ready_o;
    assign start_pkt = (state_q == ST_IDLE) & tx_valid_i & tx_sop_i &
                       (idle_cnt_q >= IDLE_MIN);
    assign comma_cnt_inc = (comma_cnt_q == 16'hFFFF) ? comma_cnt_q
                                                      : comma_cnt_q + 16'd1;

    assign tx_busy_o   = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    always_ff @(posedge ser_tx_clk_i or negedge ser_tx_rst_n) begin
        if (!ser_tx_rst_n) begin
            state_q     <= ST_IDLE;
            ser_t_o     <= K_COMMA;
            ser_tklsb_o <= 1'b1;
            ser_tkmsb_o <= 1'b1;
            tx_err_o    <= 1'b0;
            comma_cnt_q <= 16'd0;
            idle_cnt_q  <= 8'd0;
            csum_q      <= 16'd0;
            first_q     <= 1'b0;
        end else begin
            tx_err_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_pkt) begin
                        ser_t_o     <= K_SOP;
                        ser_tklsb_o <= 1'b1;
                        ser_tkmsb_o <= 1'b1;
                        comma_cnt_q <= comma_cnt_inc;
                        csum_q      <= 16'd0;
                        first_q     <= 1'b1;
                        state_q     <= ST_DATA;
                    end else begin
                        ser_t_o     <= K_COMMA;
                        ser_tklsb_o <= 1'b1;
                        ser_tkmsb_o <= 1'b1;
                        comma_cnt_q <= 16'd0;
                        if (idle_cnt_q < IDLE_MIN) begin
                            idle_cnt_q <= idle_cnt_q + 8'd1;
                        end
                    end
                    // Any accept in IDLE is a stray non-SOP word.
                    if (accept) begin
                        tx_err_o <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        ser_t_o     <= tx_data_i;
                        ser_tklsb_o <= 1'b0;
                        ser_tkmsb_o <= 1'b0;
                        comma_cnt_q <= comma_cnt_inc;
                        csum_q      <= csum_q + tx_data_i;
                        first_q     <= 1'b0;
                        // SOP is expected only on the opening word.
                        if (tx_sop_i && !first_q) begin
                            tx_err_o <= 1'b1;
                        end
                        if (tx_eop_i) begin
                            state_q <= ST_CSUM;
                        end
                    end else begin
                        // Underrun or forced clock-correction slot.
                        ser_t_o     <= K_COMMA;
                        ser_tklsb_o <= 1'b1;
                        ser_tkmsb_o <= 1'b1;
                        comma_cnt_q <= 16'd0;
                    end
                end

                ST_CSUM: begin
                    ser_t_o     <= csum_q;
                    ser_tklsb_o <= 1'b0;
                    ser_tkmsb_o <= 1'b0;
                    comma_cnt_q <= comma_cnt_inc;
                    state_q     <= ST_EOP;
                end

                ST_EOP: begin
                    ser_t_o     <= K_EOP;
                    ser_tklsb_o <= 1'b1;
                    ser_tkmsb_o <= 1'b1;
                    comma_cnt_q <= comma_cnt_inc;
                    idle_cnt_q  <= 8'd0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx_framer.sv
// Testbench for ser_tx_framer: directed scenarios followed by random packets.
// The expected non-comma output stream (SOP, payload, checksum, EOP) is built
// from each packet as it is sent; commas are checked by spacing rules.
module tb_ser_tx_framer;

    localparam int P  = 8;
    localparam int MI = 2;
    localparam logic [17:0] W_SOP = {2'b11, 16'hFBFB};
    localparam logic [17:0] W_EOP = {2'b11, 16'hFDFD};

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tx_data_i;
    logic        tx_sop_i;
    logic        tx_eop_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [15:0] ser_t_o;
    logic        ser_tklsb_o;
    logic        ser_tkmsb_o;
    logic        tx_busy_o;
    logic        tx_err_o;
    logic [1:0]  dbg_state_o;

    always #5 clk = ~clk;

    ser_tx_framer #(.COMMA_PERIOD(P), .MIN_IDLE(MI)) dut (
        .ser_tx_clk_i (clk),
        .ser_tx_rst_n (rst_n),
        .tx_data_i    (tx_data_i),
        .tx_sop_i     (tx_sop_i),
        .tx_eop_i     (tx_eop_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .ser_t_o      (ser_t_o),
        .ser_tklsb_o  (ser_tklsb_o),
        .ser_tkmsb_o  (ser_tkmsb_o),
        .tx_busy_o    (tx_busy_o),
        .tx_err_o     (tx_err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    int          err_exp = 0;
    int          err_seen = 0;
    int          run_len = 0;
    int          commas_since_eop = 0;
    int          pkt_commas = 0;
    int          last_pkt_commas = 0;
    bit          in_pkt = 1'b0;
    bit          last_was_eop = 1'b0;
    logic [15:0] pkt_data[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len          = 0;
            commas_since_eop = 0;
            in_pkt           = 1'b0;
            last_was_eop     = 1'b0;
        end else begin
            if (tx_err_o) err_seen++;
            if (ser_tklsb_o && ser_tkmsb_o && ser_t_o == 16'h3C3C) begin
                // Longest legal run: COMMA_PERIOD-1 words, or two more
                // when the run ends with checksum and EOP.
                if (run_len > 0)
                    check("comma_spacing", 32'(run_len <= (last_was_eop ? P + 1 : P - 1)), 32'd1);
                run_len = 0;
                commas_since_eop++;
                if (in_pkt) pkt_commas++;
            end else begin
                run_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none",
                             {ser_tkmsb_o, ser_tklsb_o, ser_t_o});
                    last_was_eop = 1'b0;
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_word", {14'd0, ser_tkmsb_o, ser_tklsb_o, ser_t_o}, {14'd0, exp_w});
                    if (exp_w == W_SOP) begin
                        check("min_idle", 32'(commas_since_eop >= MI), 32'd1);
                        in_pkt     = 1'b1;
                        pkt_commas = 0;
                    end
                    if (exp_w == W_EOP) begin
                        in_pkt           = 1'b0;
                        last_pkt_commas  = pkt_commas;
                        commas_since_eop = 0;
                    end
                    last_was_eop = (exp_w == W_EOP);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic idle_cycles(input int n);
        tx_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input bit s, input bit e, output bit ok);
        tx_data_i  = d;
        tx_sop_i   = s;
        tx_eop_i   = e;
        tx_valid_i = 1'b1;
        ok         = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (tx_ready_o) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0h required=accepted", d);
        end
    endtask

    task automatic send_packet(input int n, input int gap_at, input int gap_len,
                               input int sop_at, input bit rnd_gaps);
        logic [15:0] sum;
        bit          ok;
        sum = 16'd0;
        exp_q.push_back(W_SOP);
        for (int i = 0; i < n; i++) begin
            drive_word(pkt_data[i], (i == 0) || (i == sop_at), (i == n - 1), ok);
            if (ok) begin
                exp_q.push_back({2'b00, pkt_data[i]});
                sum = sum + pkt_data[i];
                if (i != 0 && i == sop_at) err_exp++;
            end
            if (i == gap_at)
                idle_cycles(gap_len);
            else if (rnd_gaps && i != n - 1 && $urandom_range(0, 3) == 0)
                idle_cycles($urandom_range(1, 3));
        end
        tx_valid_i = 1'b0;
        exp_q.push_back({2'b00, sum});
        exp_q.push_back(W_EOP);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !tx_busy_o) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (MI + 2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_word"},  {16'd0, ser_t_o}, 32'h3C3C);
        check({tag, "_klsb"},  {31'd0, ser_tklsb_o}, 32'd1);
        check({tag, "_kmsb"},  {31'd0, ser_tkmsb_o}, 32'd1);
        check({tag, "_ready"}, {31'd0, tx_ready_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, tx_busy_o}, 32'd0);
        check({tag, "_err"},   {31'd0, tx_err_o}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n;
        int sop_at;

        rst_n      = 1'b0;
        tx_data_i  = 16'd0;
        tx_sop_i   = 1'b0;
        tx_eop_i   = 1'b0;
        tx_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_dbg_busy", {31'd0, tx_busy_o}, {31'd0, (dbg_state_o != 2'd0)});
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No traffic: commas only.
        repeat (4) begin
            check_idle_outputs("no_traffic");
            @(posedge clk);
            #1;
        end

        // Single word with sop & eop.
        pkt_data[0] = 16'h1234;
        send_packet(1, -1, 0, -1, 1'b0);
        drain();
        check("single_err", err_seen, err_exp);
        check("single_pkt_commas", last_pkt_commas, 0);

        // Checksum wraps modulo 2^16.
        pkt_data[0] = 16'hFFFF;
        pkt_data[1] = 16'h0002;
        pkt_data[2] = 16'h0010;
        send_packet(3, -1, 0, -1, 1'b0);
        drain();
        check("wrap_err", err_seen, err_exp);

        // 20 words with continuous valid: one comma per COMMA_PERIOD-1 words.
        for (int i = 0; i < 20; i++) pkt_data[i] = 16'($urandom);
        send_packet(20, -1, 0, -1, 1'b0);
        drain();
        check("period_pkt_commas", last_pkt_commas, 20 / (P - 1));

        // Underrun of three cycles mid-packet.
        for (int i = 0; i < 4; i++) pkt_data[i] = 16'($urandom);
        send_packet(4, 1, 3, -1, 1'b0);
        drain();
        check("underrun_pkt_commas", last_pkt_commas, 3);

        // Stray non-SOP word in IDLE.
        drive_word(16'hABCD, 1'b0, 1'b0, ok);
        tx_valid_i = 1'b0;
        if (ok) err_exp++;
        idle_cycles(3);
        check("stray_err", err_seen, err_exp);

        // SOP on a mid-packet word.
        for (int i = 0; i < 4; i++) pkt_data[i] = 16'($urandom);
        send_packet(4, -1, 0, 2, 1'b0);
        drain();
        check("sop_in_data_err", err_seen, err_exp);

        // Asynchronous reset in the cycle after the fifth payload word.
        exp_q.push_back(W_SOP);
        for (int i = 0; i < 5; i++) begin
            pkt_data[i] = 16'($urandom);
            drive_word(pkt_data[i], (i == 0), 1'b0, ok);
            if (ok) exp_q.push_back({2'b00, pkt_data[i]});
        end
        tx_data_i = 16'h5A5A;
        tx_sop_i  = 1'b0;
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        tx_valid_i = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) pkt_data[i] = 16'($urandom);
        send_packet(6, -1, 0, -1, 1'b0);
        drain();
        check("after_reset_err", err_seen, err_exp);

        // Random packets, gaps, stray words and misplaced SOPs.
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) pkt_data[i] = 16'($urandom);
            sop_at = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
            send_packet(n, -1, 0, sop_at, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                drive_word(16'($urandom), 1'b0, 1'b0, ok);
                tx_valid_i = 1'b0;
                if (ok) err_exp++;
            end
            idle_cycles($urandom_range(0, 3));
        end
        drain();
        check("final_err", err_seen, err_exp);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
